// File: rtl/nor_funnel_pkg.sv
// Shared types and defaults for the NOR-funnel stimulus launcher.
package nor_funnel_pkg;

    localparam int unsigned NUM_LANES_DEF = 16;
    localparam int unsigned DLY_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    // Per-lane stimulus shape
    typedef struct packed {
        logic [DLY_W_DEF-1:0] delay;
        logic [DLY_W_DEF-1:0] width;
        logic                 idle;
        logic                 en;
    } lane_cfg_t;

endpackage

// File: rtl/nor_funnel_lane.sv
// One stimulus lane: drives the active level while the run counter is inside
// the window [delay, delay+width), otherwise the idle level.
module nor_funnel_lane
    import nor_funnel_pkg::*;
#(
    parameter int unsigned T_W = DLY_W_DEF + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    input  logic [T_W-1:0] t,
    input  lane_cfg_t      cfg,
    output logic           lane_out
);

    logic [T_W-1:0] win_lo;
    logic [T_W-1:0] win_hi;
    logic           in_win;

    assign win_lo = T_W'(cfg.delay);
    assign win_hi = T_W'(cfg.delay) + T_W'(cfg.width);
    assign in_win = cfg.en && (t >= win_lo) && (t < win_hi);

    // Registered lane drive; idle level whenever no run is in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_out <= 1'b0;
        end else begin
            lane_out <= run ? (cfg.idle ^ in_win) : cfg.idle;
        end
    end

endmodule

// File: rtl/nor_funnel_stim.sv
// NOR-funnel stimulus launcher: turns one start request into NUM_LANES timed
// pulses referenced to a shared run counter.
// Optional return-path monitor enabled by defining FUNNEL_MON_EN.
module nor_funnel_stim
    import nor_funnel_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned LANE_W    = $clog2(NUM_LANES),
    parameter int unsigned DLY_W     = DLY_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [LANE_W-1:0]    cfg_lane,
    input  logic [DLY_W-1:0]     cfg_delay,
    input  logic [DLY_W-1:0]     cfg_width,
    input  logic                 cfg_idle,
    input  logic                 cfg_en,
    input  logic                 start,
    output logic [NUM_LANES-1:0] lane_out,
    output logic                 busy,
    output logic                 done,
    output logic [DLY_W:0]       run_len
`ifdef FUNNEL_MON_EN
    ,
    input  logic                 funnel_out,
    output logic [7:0]           edge_cnt,
    output logic                 final_lvl
`endif
);

    localparam int unsigned T_W = DLY_W + 1;

    state_t         state;
    state_t         next_state;
    lane_cfg_t      cfg_q [NUM_LANES];
    logic [T_W-1:0] t;
    logic [T_W-1:0] end_c;
    logic [T_W-1:0] sum_c;

    // Run end time: latest window close over enabled lanes
    always_comb begin
        end_c = '0;
        sum_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_c = T_W'(cfg_q[i].delay) + T_W'(cfg_q[i].width);
            if (cfg_q[i].en && (sum_c > end_c)) begin
                end_c = sum_c;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a same-cycle config write wins over start
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start && !cfg_we) next_state = ST_ARM;
            ST_ARM:  next_state = (end_c == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (t == run_len - T_W'(1)) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Run counter, run length and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t       <= '0;
            run_len <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (state == ST_ARM) begin
                t       <= '0;
                run_len <= end_c;
            end else if (state == ST_RUN) begin
                t <= t + T_W'(1);
            end
            busy <= (state == ST_ARM) || (state == ST_RUN);
            done <= (state == ST_DONE);
        end
    end

    // Config storage; writable only while idle, out-of-range lanes match nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cfg_q[i] <= '0;
            end
        end else if ((state == ST_IDLE) && cfg_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (cfg_lane == LANE_W'(i)) begin
                    cfg_q[i] <= '{delay: DLY_W_DEF'(cfg_delay),
                                  width: DLY_W_DEF'(cfg_width),
                                  idle:  cfg_idle,
                                  en:    cfg_en};
                end
            end
        end
    end

    // Per-lane compare-and-drive
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        nor_funnel_lane #(
            .T_W(T_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (state == ST_RUN),
            .t        (t),
            .cfg      (cfg_q[g]),
            .lane_out (lane_out[g])
        );
    end

`ifdef FUNNEL_MON_EN
    logic [1:0] sync_q;
    logic       lvl_q;

    // Return-path monitor: synchronize, count edges during a run, capture final level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            lvl_q     <= 1'b0;
            edge_cnt  <= '0;
            final_lvl <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], funnel_out};
            lvl_q  <= sync_q[1];
            if ((state == ST_IDLE) && (next_state == ST_ARM)) begin
                edge_cnt <= '0;
            end else if ((state != ST_IDLE) && (sync_q[1] != lvl_q) && (edge_cnt != 8'hFF)) begin
                edge_cnt <= edge_cnt + 8'd1;
            end
            if (state == ST_DONE) begin
                final_lvl <= sync_q[1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_nor_funnel_stim.sv
// Directed bench for nor_funnel_stim; define FUNNEL_MON_EN to also cover the monitor.
module tb_nor_funnel_stim;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_lane;
    logic [7:0]  cfg_delay;
    logic [7:0]  cfg_width;
    logic        cfg_idle;
    logic        cfg_en;
    logic        start;
    logic [15:0] lane_out;
    logic        busy;
    logic        done;
    logic [8:0]  run_len;
`ifdef FUNNEL_MON_EN
    logic        funnel_out;
    logic [7:0]  edge_cnt;
    logic        final_lvl;
`endif

    int total = 0;
    int bad   = 0;

    // Expected lane configuration held by the bench
    int m_d    [16];
    int m_w    [16];
    int m_idle [16];
    int m_en   [16];

    nor_funnel_stim dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_idle  (cfg_idle),
        .cfg_en    (cfg_en),
        .start     (start),
        .lane_out  (lane_out),
        .busy      (busy),
        .done      (done),
        .run_len   (run_len)
`ifdef FUNNEL_MON_EN
        ,
        .funnel_out(funnel_out),
        .edge_cnt  (edge_cnt),
        .final_lvl (final_lvl)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_d[i] = 0; m_w[i] = 0; m_idle[i] = 0; m_en[i] = 0;
        end
    endtask

    task automatic do_reset();
        cfg_we = 1'b0;
        start  = 1'b0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        clear_model();
    endtask

    task automatic wr(input int lane, input int d, input int w, input int idle, input int en);
        cfg_we    = 1'b1;
        cfg_lane  = 4'(lane);
        cfg_delay = 8'(d);
        cfg_width = 8'(w);
        cfg_idle  = 1'(idle);
        cfg_en    = 1'(en);
        tick();
        cfg_we    = 1'b0;
        m_d[lane] = d; m_w[lane] = w; m_idle[lane] = idle; m_en[lane] = en;
    endtask

    // Expected lane drive k cycles after the start-sampling edge
    function automatic logic [15:0] model(input int k);
        logic [15:0] e;
        logic        act;
        for (int i = 0; i < 16; i++) begin
            act  = (m_en[i] != 0) && (k >= m_d[i] + 2) && (k < m_d[i] + m_w[i] + 2);
            e[i] = 1'(m_idle[i]) ^ act;
        end
        return e;
    endfunction

    // Launch one run and check every cycle; optionally inject ignored cfg_we/start at cycle inj_k
    task automatic run_check(input string tag, input int exp_end, input int inj_k);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= exp_end + 3; k++) begin
            chk({tag, "_lane"}, 32'(lane_out), 32'(model(k)));
            chk({tag, "_busy"}, 32'(busy), 32'((k >= 1) && (k <= exp_end + 1)));
            chk({tag, "_done"}, 32'(done), 32'(k == exp_end + 2));
            if (k >= 1) chk({tag, "_runlen"}, 32'(run_len), 32'(exp_end));
            if (k == inj_k) begin
                cfg_we = 1'b1; cfg_lane = 4'd0; cfg_delay = 8'd0; cfg_width = 8'd50;
                cfg_idle = 1'b1; cfg_en = 1'b1; start = 1'b1;
            end else begin
                cfg_we = 1'b0; start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        clk = 1'b0;
        cfg_lane = '0; cfg_delay = '0; cfg_width = '0; cfg_idle = 1'b0; cfg_en = 1'b0;
`ifdef FUNNEL_MON_EN
        funnel_out = 1'b0;
`endif
        do_reset();

        chk("rst_lane", 32'(lane_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_runlen", 32'(run_len), 32'h0);
        tick();

        // Empty run: ARM then DONE
        run_check("empty", 0, -1);

        // Single lane pulse, d=3 w=2
        wr(0, 3, 2, 0, 1);
        run_check("l0", 5, -1);

        // Walking zero across all lanes
        for (int i = 0; i < 16; i++) wr(i, i, 1, 1, 1);
        run_check("walk", 16, -1);

        // Maximum window, counter must not wrap
        do_reset();
        wr(5, 255, 255, 0, 1);
        run_check("long", 510, -1);

        // Writes and start during a run are dropped, not queued
        do_reset();
        wr(0, 3, 2, 0, 1);
        run_check("ign", 5, 3);
        for (int i = 0; i < 3; i++) begin
            chk("noqueue_busy", 32'(busy), 32'h0);
            tick();
        end
        run_check("frozen", 5, -1);

        // Reset in the middle of a run
        do_reset();
        wr(2, 5, 2, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_lane_pre", 32'(lane_out), 32'h0004);
        chk("mid_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_model();
        chk("mid_lane", 32'(lane_out), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_done", 32'(done), 32'h0);
        chk("mid_runlen", 32'(run_len), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_nodone", 32'(done), 32'h0);
            chk("mid_idle_lane", 32'(lane_out), 32'h0);
        end

`ifdef FUNNEL_MON_EN
        // Monitor: three toggles during the run
        do_reset();
        funnel_out = 1'b0;
        wr(0, 3, 10, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k == 3 || k == 5 || k == 7) funnel_out = ~funnel_out;
            tick();
        end
        chk("mon_done", 32'(done), 32'h1);
        chk("mon_edges", 32'(edge_cnt), 32'd3);
        chk("mon_final", 32'(final_lvl), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
